fb_dac_driver: RTL

Feedback DAC output stage that consumes the per-bunch correction word and the `fb_cond`/`dac_clk` strobes produced by the DSP calculation stage. It captures the correction during the `fb_cond` window, averages the samples, applies gain and saturation, and converts the result to offset-binary. It then presents the word to the DAC with a delayed write strobe. When a DAC strobe arrives with no pending sample, it drives mid-scale, so the end-of-store clear pulses zero the kicker.

---
 rtl/fb_dac_pkg.sv | 27 ++
 rtl/fb_dac_driver_if.sv | 29 ++
 rtl/fb_dac_sat.sv | 35 +++
 rtl/fb_dac_driver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fb_dac_pkg.sv
// Shared types and constants for the feedback DAC output stage.
package fb_dac_pkg;

  localparam int unsigned OUT_W   = 14;
  localparam int unsigned IN_W    = 15;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ACC_W   = IN_W + 1;
  localparam int unsigned SHIFT_W = 3;
  localparam int unsigned SH_W    = 23;

  localparam logic [OUT_W-1:0] DAC_MID = 14'h2000;
  localparam int               SAT_MAX = 8191;
  localparam int               SAT_MIN = -8192;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ARMED   = 2'd2
  } state_e;

  // Result of the shift/clip/offset-binary stage.
  typedef struct packed {
    logic             clipped;
    logic [OUT_W-1:0] code;
  } dac_word_t;

endpackage

// File: rtl/fb_dac_driver_if.sv
// DSP-side strobes/data into the DAC driver and the DAC-side results out of it.
interface fb_dac_driver_if;
  import fb_dac_pkg::*;

  logic                    fb_en;
  logic signed [IN_W-1:0]  pout_in;
  logic                    dsp_oflow_in;
  logic                    fb_cond_in;
  logic                    dac_clk_in;
  logic [SHIFT_W-1:0]      gain_shift;

  logic [OUT_W-1:0]        dac_data;
  logic                    dac_wr;
  logic                    sat_flag;
  logic                    oflow_sticky;
  logic [CNT_W-1:0]        write_count;
  logic                    busy;

  modport master (
    output fb_en, pout_in, dsp_oflow_in, fb_cond_in, dac_clk_in, gain_shift,
    input  dac_data, dac_wr, sat_flag, oflow_sticky, write_count, busy
  );

  modport slave (
    input  fb_en, pout_in, dsp_oflow_in, fb_cond_in, dac_clk_in, gain_shift,
    output dac_data, dac_wr, sat_flag, oflow_sticky, write_count, busy
  );

endinterface

// File: rtl/fb_dac_sat.sv
// Combinational gain shift, clip to the DAC range and offset-binary conversion.
module fb_dac_sat
  import fb_dac_pkg::*;
(
  input  logic signed [ACC_W-1:0] val_i,
  input  logic [SHIFT_W-1:0]      gain_shift_i,
  output dac_word_t               word_c
);

  localparam logic signed [SH_W-1:0] SH_MAX = SH_W'(SAT_MAX);
  localparam logic signed [SH_W-1:0] SH_MIN = SH_W'(SAT_MIN);

  logic signed [SH_W-1:0] val_ext;
  logic signed [SH_W-1:0] shifted;
  logic signed [SH_W-1:0] clipped;
  logic                   clip;

  always_comb begin
    val_ext = {{(SH_W-ACC_W){val_i[ACC_W-1]}}, val_i};
    shifted = val_ext <<< gain_shift_i;
    clip    = 1'b0;
    clipped = shifted;
    if (shifted > SH_MAX) begin
      clipped = SH_MAX;
      clip    = 1'b1;
    end else if (shifted < SH_MIN) begin
      clipped = SH_MIN;
      clip    = 1'b1;
    end
    // Flipping the sign bit of the 14-bit two's complement value adds mid-scale.
    word_c.clipped = clip;
    word_c.code    = {~clipped[OUT_W-1], clipped[OUT_W-2:0]};
  end

endmodule

// File: rtl/fb_dac_driver.sv
// Feedback DAC output stage: capture/average correction, gain+clip, delayed DAC write strobe.
// Build option FB_DAC_AVG_EN: average two samples per fb_cond window instead of keeping the last.
module fb_dac_driver
  import fb_dac_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fb_dac_driver_if.slave bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
`ifdef FB_DAC_AVG_EN
  logic                    n_q, n_d;
`endif
  logic                    oflow_cap_q, oflow_cap_d;
  logic                    clk_seen_q, clk_seen_d;
  logic                    clk_d1_q, clk_d1_d;
  logic                    dac_wr_q, dac_wr_d;
  logic [OUT_W-1:0]        dac_data_q, dac_data_d;
  logic                    sat_flag_q, sat_flag_d;
  logic                    oflow_sticky_q, oflow_sticky_d;
  logic [CNT_W-1:0]        write_count_q, write_count_d;
  logic                    busy_q, busy_d;

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] val;
  dac_word_t               sat_word;

  assign sample_ext = {bus.pout_in[IN_W-1], bus.pout_in};

`ifdef FB_DAC_AVG_EN
  assign val = n_q ? (acc_q >>> 1) : acc_q;
`else
  assign val = acc_q;
`endif

  fb_dac_sat u_sat (
    .val_i        (val),
    .gain_shift_i (bus.gain_shift),
    .word_c       (sat_word)
  );

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
`ifdef FB_DAC_AVG_EN
    n_d            = n_q;
`endif
    oflow_cap_d    = oflow_cap_q;
    clk_seen_d     = clk_seen_q;
    clk_d1_d       = bus.dac_clk_in;
    dac_wr_d       = clk_d1_q;
    dac_data_d     = dac_data_q;
    sat_flag_d     = sat_flag_q;
    oflow_sticky_d = oflow_sticky_q;

    if (!bus.fb_en) begin
      state_d    = IDLE;
      dac_data_d = DAC_MID;
      clk_d1_d   = 1'b0;
      dac_wr_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Strobe with nothing pending: clear the kicker to mid-scale.
          if (bus.dac_clk_in) dac_data_d = DAC_MID;
          if (bus.fb_cond_in) begin
            state_d     = CAPTURE;
            acc_d       = sample_ext;
`ifdef FB_DAC_AVG_EN
            n_d         = 1'b0;
`endif
            oflow_cap_d = bus.dsp_oflow_in;
          end
        end
        CAPTURE: begin
          if (bus.fb_cond_in) begin
`ifdef FB_DAC_AVG_EN
            if (!n_q) begin
              acc_d = acc_q + sample_ext;
              n_d   = 1'b1;
            end
`else
            acc_d = sample_ext;
`endif
            oflow_cap_d = oflow_cap_q | bus.dsp_oflow_in;
          end else begin
            state_d    = ARMED;
            clk_seen_d = 1'b0;
            if (oflow_cap_q) begin
              dac_data_d     = DAC_MID;
              sat_flag_d     = 1'b0;
              oflow_sticky_d = 1'b1;
            end else begin
              dac_data_d = sat_word.code;
              sat_flag_d = sat_word.clipped;
            end
          end
        end
        ARMED: begin
          if (bus.fb_cond_in) begin
            state_d     = CAPTURE;
            acc_d       = sample_ext;
`ifdef FB_DAC_AVG_EN
            n_d         = 1'b0;
`endif
            oflow_cap_d = bus.dsp_oflow_in;
          end else if (clk_seen_q && !bus.dac_clk_in) begin
            state_d = IDLE;
          end else if (bus.dac_clk_in) begin
            clk_seen_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    write_count_d = write_count_q + CNT_W'(dac_wr_d & ~dac_wr_q);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
`ifdef FB_DAC_AVG_EN
      n_q            <= 1'b0;
`endif
      oflow_cap_q    <= 1'b0;
      clk_seen_q     <= 1'b0;
      clk_d1_q       <= 1'b0;
      dac_wr_q       <= 1'b0;
      dac_data_q     <= DAC_MID;
      sat_flag_q     <= 1'b0;
      oflow_sticky_q <= 1'b0;
      write_count_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
`ifdef FB_DAC_AVG_EN
      n_q            <= n_d;
`endif
      oflow_cap_q    <= oflow_cap_d;
      clk_seen_q     <= clk_seen_d;
      clk_d1_q       <= clk_d1_d;
      dac_wr_q       <= dac_wr_d;
      dac_data_q     <= dac_data_d;
      sat_flag_q     <= sat_flag_d;
      oflow_sticky_q <= oflow_sticky_d;
      write_count_q  <= write_count_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.dac_data     = dac_data_q;
  assign bus.dac_wr       = dac_wr_q;
  assign bus.sat_flag     = sat_flag_q;
  assign bus.oflow_sticky = oflow_sticky_q;
  assign bus.write_count  = write_count_q;
  assign bus.busy         = busy_q;

endmodule
